// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported unified memory between the processor's
//             instruction-fetch port and its data (load/store) port. Requests
//             are serialized, the memory request is held stable until m_ack
//             or a timeout abort, and a one-cycle ack (with error flag) plus
//             read data is returned to the winning requester.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             i_req/i_addr        - instruction fetch request
//             i_ack/i_err/i_rdata - fetch completion, timeout flag, data
//             d_req/d_rd_wr/d_addr/d_wdata - data request (1 = read)
//             d_ack/d_err/d_rdata - data completion, timeout flag, load data
//             m_req/m_rd_wr/m_addr/m_wdata - memory request side
//             m_ack/m_rdata       - memory completion and read data
//             busy                - high whenever the FSM is not IDLE
//  Params   : TIMEOUT_CYCLES      - cycles to wait for m_ack (0 = no timeout)
//  Options  : MEM_ARB_ROUND_ROBIN_EN - when defined, ties between i_req and
//             d_req alternate using a last_grant register; when undefined,
//             data always beats instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_rd_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    // memory port
    output logic        m_req,
    output logic        m_rd_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    // status
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    // 17 bits so the compare against a 16-bit counter plus one never wraps.
    localparam logic [16:0] C_TIMEOUT    = 17'(TIMEOUT_CYCLES);
    localparam logic        C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t      state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic        m_req_q,   m_req_d;
    logic        m_rd_wr_q, m_rd_wr_d;
    logic [31:0] m_addr_q,  m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_ack_q,   i_ack_d;
    logic        i_err_q,   i_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_ack_q,   d_ack_d;
    logic        d_err_q,   d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        busy_q,    busy_d;

    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_timeout;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic C_GRANT_INSTR = 1'b0;
    localparam logic C_GRANT_DATA  = 1'b1;

    logic last_grant_q, last_grant_d;

    // On a tie, serve the port that did not win last time.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (i_req && d_req) begin
            w_grant_i = (last_grant_q == C_GRANT_DATA);
            w_grant_d = (last_grant_q == C_GRANT_INSTR);
        end else begin
            w_grant_i = i_req;
            w_grant_d = d_req;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (w_grant_d) begin
                last_grant_d = C_GRANT_DATA;
            end else if (w_grant_i) begin
                last_grant_d = C_GRANT_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= C_GRANT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: data beats instruction.
    always_comb begin
        w_grant_d = d_req;
        w_grant_i = i_req && !d_req;
    end
`endif

    // Abort on the edge where the counter would reach TIMEOUT_CYCLES, so m_req
    // stays high for exactly TIMEOUT_CYCLES cycles.
    always_comb begin
        w_timeout = C_TIMEOUT_EN && (({1'b0, cnt_q} + 17'd1) == C_TIMEOUT);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_rd_wr_d = m_rd_wr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    m_req_d   = 1'b1;
                    m_addr_d  = d_addr;
                    m_rd_wr_d = d_rd_wr;
                    m_wdata_d = d_wdata;
                    cnt_d     = 16'd0;
                    state_d   = MEM_D;
                end else if (w_grant_i) begin
                    m_req_d   = 1'b1;
                    m_addr_d  = i_addr;
                    m_rd_wr_d = 1'b1;
                    m_wdata_d = 32'd0;
                    cnt_d     = 16'd0;
                    state_d   = MEM_I;
                end
            end

            MEM_I, MEM_D: begin
                // m_ack takes precedence over a coinciding timeout.
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (state_q == MEM_I) begin
                        i_ack_d = 1'b1;
                        if (m_rd_wr_q) begin
                            i_rdata_d = m_rdata;
                        end
                    end else begin
                        d_ack_d = 1'b1;
                        if (m_rd_wr_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (w_timeout) begin
                        m_req_d = 1'b0;
                        state_d = RESP;
                        if (state_q == MEM_I) begin
                            i_ack_d   = 1'b1;
                            i_err_d   = 1'b1;
                            i_rdata_d = 32'd0;
                        end else begin
                            d_ack_d   = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = 32'd0;
                        end
                    end
                end
            end

            RESP: begin
                // Requests and late m_ack are ignored here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            m_req_q   <= 1'b0;
            m_rd_wr_q <= 1'b1;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            i_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_rd_wr_q <= m_rd_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            i_err_q   <= i_err_d;
            i_rdata_q <= i_rdata_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_rd_wr = m_rd_wr_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign i_err   = i_err_q;
    assign i_rdata = i_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the processor's instruction-fetch port and its data (load/store) port.
- Serializes requests and holds the memory request stable until the memory acknowledges it.
- Returns read data and a one-cycle acknowledge to the winning requester.
- A timeout counter aborts hung transactions with an error flag so the core cannot deadlock.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for m_ack before aborting; legal range 0..65535; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_req  in  1  instruction fetch request (level)
- i_addr  in  32  fetch address
- i_ack  out  1  one-cycle pulse: fetch complete
- i_err  out  1  valid with i_ack; 1 means timed out
- i_rdata  out  32  fetched word, valid with i_ack
- d_req  in  1  data request (level)
- d_rd_wr  in  1  1 = read, 0 = write
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse: data access complete
- d_err  out  1  valid with d_ack; 1 means timed out
- d_rdata  out  32  load data, valid with d_ack
- m_req  out  1  memory request, held until m_ack or abort
- m_rd_wr  out  1  1 = read, 0 = write
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_ack  in  1  memory completion, sampled at posedge
- m_rdata  in  32  memory read data, valid with m_ack
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values: i_ack, i_err, d_ack, d_err, m_req, busy = 0; i_rdata, d_rdata, m_addr, m_wdata = 0; m_rd_wr = 1; FSM = IDLE; timeout counter = 0; last_grant = DATA.
- FSM states: IDLE, MEM_I, MEM_D, RESP.
- IDLE:
  - On a posedge with any request, latch the winner's address (plus rd_wr and wdata for data), set m_req = 1, clear the counter, and go to MEM_I or MEM_D.
  - Instruction grants force m_rd_wr = 1 and m_wdata = 0.
- Arbitration: fixed priority, d_req beats i_req when both are high in the same IDLE cycle. This is overridden when the optional feature is enabled.
- MEM_x:
  - m_addr, m_rd_wr and m_wdata stay constant; requester input changes are ignored until completion.
  - On m_ack = 1: m_req goes to 0; x_rdata is loaded with m_rdata on reads and left unchanged on writes; x_ack = 1 and x_err = 0 for one cycle; go to RESP.
  - On m_ack = 0: increment the counter (16-bit).
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: m_req goes to 0; x_rdata is set to 0; x_ack = 1 and x_err = 1 for one cycle; go to RESP.
  - If m_ack and the timeout coincide in the same cycle, m_ack wins and x_err = 0.
- RESP:
  - The ack/err pulse is visible for this one cycle; then both return to 0 and the FSM goes to IDLE.
  - Requests are not sampled in RESP.
- Back-to-back: a requester that still has req high in the IDLE cycle after RESP starts a new transaction.
- Latency: req high in cycle 0 → m_req in cycle 1 → with m_ack in cycle 1, x_ack in cycle 2. Minimum 3 cycles per transaction, including IDLE.
- A late m_ack arriving after an abort, while in RESP or IDLE, is ignored.
- Reset mid-transaction: the outstanding access is dropped with no ack; m_req goes to 0 at the reset edge.
- busy = 1 in MEM_I, MEM_D and RESP.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN
- Defined:
  - A last_grant register records the port granted most recently.
  - On a simultaneous i_req/d_req, grant the port not in last_grant; last_grant updates on every grant.
  - Reset value last_grant = DATA, so the first tie goes to instruction.
  - A single request is always granted.
- Undefined: fixed data-over-instruction priority; no last_grant register.

Test Plan:
- Reset then i_req = 1, i_addr = 0x0000_0040, memory acks 1 cycle after m_req with m_rdata = 0x2409_0005 → m_req/m_addr = 0x40/m_rd_wr = 1 in cycle 1; i_ack = 1, i_err = 0, i_rdata = 0x2409_0005 in cycle 3; busy falls in cycle 4.
- d_req store, d_rd_wr = 0, d_addr = 0x100, d_wdata = 0xCAFE_F00D, memory acks after 4 cycles → m_wdata = 0xCAFE_F00D held stable for all 4 cycles; d_ack pulses once; d_rdata unchanged.
- i_req and d_req raised together in the same cycle, both held → without the macro, data is served first, then instruction. With MEM_ARB_ROUND_ROBIN_EN, instruction is served first, then data, then instruction (alternation).
- TIMEOUT_CYCLES = 8, m_ack held 0 → after 8 cycles in MEM_D: m_req drops, d_ack = 1, d_err = 1, d_rdata = 0. A later m_ack is ignored.
- reset asserted while in MEM_I with m_req = 1 → m_req, busy = 0 at the reset edge; no i_ack ever pulses; next request proceeds normally.
- m_ack arrives in the same cycle the counter hits TIMEOUT_CYCLES = 3 → x_ack = 1, x_err = 0, rdata = m_rdata.
